// File: rtl/controller.sv
// Multi-cycle control unit for the 19-bit-instruction, 8-bit datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB/HALT, drives every datapath strobe
// and select from the current state and the latched opcode, and counts
// retired instructions (one per pcEn pulse).
//
// Handshake: there is no valid/ready pair; each strobe is a single-cycle,
// active-high command that the datapath acts on at the next rising edge.
// The instruction word is stable for the whole instruction because PC only
// advances on the edge that ends the instruction's last cycle.
//
// dbg_state exposes the FSM state for checkers:
//   0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT.
module controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       opcode,
  output logic             pcEn,
  output logic             CEn,
  output logic             ZEn,
  output logic             regWrite,
  output logic             regFileReadRegister2Select,
  output logic             ALUBInputSelect,
  output logic [2:0]       ALUOperation,
  output logic [1:0]       SHROOperation,
  output logic [1:0]       regFileWriteDataSelect,
  output logic             DMMemRead,
  output logic             DMMemWrite,
  output logic             halted,
  output logic [CNT_W-1:0] instrCount,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [4:0]       r_op_q;
  logic [CNT_W-1:0] r_count;

  // In DECODE the latch has not been loaded yet, so decode straight from
  // the opcode input; every later cycle uses the latched copy.
  logic [4:0] w_op;
  logic       w_is_alu_r;
  logic       w_is_alu_i;
  logic       w_is_mem;
  logic       w_is_store;
  logic       w_is_shift;
  logic       w_is_halt;
  logic       w_is_nop;

  assign w_op       = (r_state == S_DECODE) ? opcode : r_op_q;
  assign w_is_alu_r = (w_op[4:3] == 2'b00);
  assign w_is_alu_i = (w_op[4:3] == 2'b01);
  assign w_is_mem   = (w_op[4:2] == 3'b100);
  assign w_is_store = w_is_mem & w_op[0];
  assign w_is_shift = (w_op[4:2] == 3'b101);
  assign w_is_halt  = (w_op == 5'b11111);
  assign w_is_nop   = (w_op[4:3] == 2'b11) & ~w_is_halt;

  // State register and opcode latch; the opcode is captured only in DECODE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_op_q  <= 5'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op_q <= opcode;
      end
    end
  end

  // Retired-instruction counter: one count per pcEn pulse, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (pcEn) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Next state, strobes and selects. Selects are held from DECODE through
  // the instruction's last cycle and read zero in FETCH and HALT.
  always_comb begin
    w_next                     = r_state;
    pcEn                       = 1'b0;
    CEn                        = 1'b0;
    ZEn                        = 1'b0;
    regWrite                   = 1'b0;
    regFileReadRegister2Select = 1'b0;
    ALUBInputSelect            = 1'b0;
    ALUOperation               = 3'b000;
    SHROOperation              = 2'b00;
    regFileWriteDataSelect     = 2'b00;
    DMMemRead                  = 1'b0;
    DMMemWrite                 = 1'b0;
    halted                     = 1'b0;

    if (r_state == S_DECODE || r_state == S_EXEC ||
        r_state == S_MEM    || r_state == S_WB) begin
      if (w_is_alu_r) begin
        ALUOperation               = w_op[2:0];
        ALUBInputSelect            = 1'b1;
        regFileReadRegister2Select = 1'b1;
      end else if (w_is_alu_i) begin
        ALUOperation = w_op[2:0];
      end else if (w_is_shift) begin
        SHROOperation          = w_op[1:0];
        regFileWriteDataSelect = 2'b01;
      end else if (w_is_mem && !w_is_store) begin
        regFileWriteDataSelect = 2'b10;
      end
    end

    case (r_state)
      S_FETCH: begin
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_nop) begin
          pcEn   = 1'b1;
          w_next = S_FETCH;
        end else if (w_is_halt) begin
          w_next = S_HALT;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_alu_r || w_is_alu_i) begin
          regWrite = 1'b1;
          CEn      = 1'b1;
          ZEn      = 1'b1;
          pcEn     = 1'b1;
          w_next   = S_FETCH;
        end else if (w_is_shift) begin
          regWrite = 1'b1;
          pcEn     = 1'b1;
          w_next   = S_FETCH;
        end else if (w_is_mem) begin
          w_next = S_MEM;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEM: begin
        if (w_is_store) begin
          DMMemWrite = 1'b1;
          pcEn       = 1'b1;
          w_next     = S_FETCH;
        end else begin
          DMMemRead = 1'b1;
          w_next    = S_WB;
        end
      end
      S_WB: begin
        DMMemRead = 1'b1;
        regWrite  = 1'b1;
        pcEn      = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  assign instrCount = r_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller. A driver issues instructions and
// pushes the per-cycle expected outputs, computed from the instruction's
// class and cycle index, into exp_q; a monitor pops and compares once per
// cycle on the falling edge. Reset behaviour is checked directly.
module tb_controller;

  localparam int CNT_W = 4;
  localparam int OW    = 16 + CNT_W;

  localparam int C_R   = 0;
  localparam int C_I   = 1;
  localparam int C_LD  = 2;
  localparam int C_ST  = 3;
  localparam int C_SH  = 4;
  localparam int C_NOP = 5;
  localparam int C_HLT = 6;

  logic             clk;
  logic             rst;
  logic [4:0]       opcode;
  logic             pcEn;
  logic             CEn;
  logic             ZEn;
  logic             regWrite;
  logic             regFileReadRegister2Select;
  logic             ALUBInputSelect;
  logic [2:0]       ALUOperation;
  logic [1:0]       SHROOperation;
  logic [1:0]       regFileWriteDataSelect;
  logic             DMMemRead;
  logic             DMMemWrite;
  logic             halted;
  logic [CNT_W-1:0] instrCount;
  logic [2:0]       dbg_state;

  logic [OW-1:0]    exp_q[$];
  logic [OW-1:0]    act;
  logic [CNT_W-1:0] cnt;
  bit               fresh;
  int               checks;
  int               failures;

  controller #(.CNT_W(CNT_W)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .opcode                     (opcode),
    .pcEn                       (pcEn),
    .CEn                        (CEn),
    .ZEn                        (ZEn),
    .regWrite                   (regWrite),
    .regFileReadRegister2Select (regFileReadRegister2Select),
    .ALUBInputSelect            (ALUBInputSelect),
    .ALUOperation               (ALUOperation),
    .SHROOperation              (SHROOperation),
    .regFileWriteDataSelect     (regFileWriteDataSelect),
    .DMMemRead                  (DMMemRead),
    .DMMemWrite                 (DMMemWrite),
    .halted                     (halted),
    .instrCount                 (instrCount),
    .dbg_state                  (dbg_state)
  );

  assign act = {halted, pcEn, CEn, ZEn, regWrite, regFileReadRegister2Select,
                ALUBInputSelect, ALUOperation, SHROOperation,
                regFileWriteDataSelect, DMMemRead, DMMemWrite, instrCount};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int classify(input logic [4:0] op);
    int v;
    v = int'(op);
    if (v == 31)      return C_HLT;
    else if (v >= 24) return C_NOP;
    else if (v >= 20) return C_SH;
    else if (v >= 16) return (v % 2 == 1) ? C_ST : C_LD;
    else if (v >= 8)  return C_I;
    else              return C_R;
  endfunction

  function automatic int instr_len(input int cls);
    case (cls)
      C_NOP:   return 2;
      C_ST:    return 4;
      C_LD:    return 5;
      default: return 3;
    endcase
  endfunction

  // Expected outputs of cycle idx of an instruction (idx 0 is the fetch).
  function automatic logic [OW-1:0] exp_cycle(input logic [4:0] op, input int idx,
                                               input logic [CNT_W-1:0] c);
    int         cls;
    logic       h, pc, cf, zf, rw, r2, bs, rd, wr;
    logic [2:0] alu;
    logic [1:0] sh, wd;
    cls = classify(op);
    {h, pc, cf, zf, rw, r2, bs, rd, wr} = '0;
    alu = 3'd0; sh = 2'd0; wd = 2'd0;
    if (cls == C_HLT) begin
      h = (idx >= 2);
    end else if (idx >= 1) begin
      if (cls == C_R)  begin alu = op[2:0]; bs = 1'b1; r2 = 1'b1; end
      if (cls == C_I)  alu = op[2:0];
      if (cls == C_SH) begin sh = op[1:0]; wd = 2'b01; end
      if (cls == C_LD) wd = 2'b10;
      if (cls == C_NOP && idx == 1) pc = 1'b1;
      if ((cls == C_R || cls == C_I) && idx == 2) {rw, cf, zf, pc} = 4'hF;
      if (cls == C_SH && idx == 2) {rw, pc} = 2'b11;
      if (cls == C_ST && idx == 3) {wr, pc} = 2'b11;
      if (cls == C_LD && idx == 3) rd = 1'b1;
      if (cls == C_LD && idx == 4) {rd, rw, pc} = 3'b111;
    end
    return {h, pc, cf, zf, rw, r2, bs, alu, sh, wd, rd, wr, c};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [OW-1:0] a, input logic [OW-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h at %0t", name, a, e, $time);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, act, '0);
    check({name, "_state"}, OW'(dbg_state), OW'(0));
  endtask

  // Monitor: one comparison per cycle while out of reset.
  always @(negedge clk) begin
    if (rst && exp_q.size() > 0) begin
      check("cycle", act, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    if (!fresh) begin
      @(posedge clk);
      #1;
    end
    fresh = 1'b0;
  endtask

  task automatic push_cycle(input logic [4:0] op, input int idx);
    logic [OW-1:0] e;
    e = exp_cycle(op, idx, cnt);
    exp_q.push_back(e);
    if (e[OW-2]) cnt = cnt + 1'b1;
  endtask

  // Opcode carries the real value only in DECODE; noise elsewhere.
  task automatic run_instr(input logic [4:0] op, input int n_halt);
    int len;
    len = (classify(op) == C_HLT) ? 2 + n_halt : instr_len(classify(op));
    for (int idx = 0; idx < len; idx++) begin
      next_cycle();
      opcode = (idx == 1) ? op : 5'($urandom_range(0, 31));
      push_cycle(op, idx);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst   = 1'b1;
    fresh = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_zero("reset");
    exp_q.delete();
    cnt = '0;
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  // LOAD interrupted by an asynchronous reset in the middle of WB.
  task automatic load_with_reset();
    for (int idx = 0; idx < 4; idx++) begin
      next_cycle();
      opcode = (idx == 1) ? 5'b10000 : 5'($urandom_range(0, 31));
      push_cycle(5'b10000, idx);
    end
    @(posedge clk);
    #2;
    check("wb_before_reset", act, exp_cycle(5'b10000, 4, cnt));
    rst = 1'b0;
    #1;
    check_zero("mid_wb_reset");
    exp_q.delete();
    cnt = '0;
    repeat (2) begin
      @(negedge clk);
      check_zero("reset_hold");
    end
    release_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    cnt      = '0;
    fresh    = 1'b0;
    rst      = 1'b0;
    opcode   = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("power_on");
    release_reset();

    run_instr(5'b00010, 0);
    run_instr(5'b01101, 0);
    run_instr(5'b10110, 0);
    run_instr(5'b10000, 0);
    run_instr(5'b10001, 0);
    run_instr(5'b11000, 0);

    repeat (60) run_instr(5'($urandom_range(0, 30)), 0);

    load_with_reset();
    run_instr(5'b00011, 0);
    run_instr(5'($urandom_range(0, 30)), 0);

    do_reset();
    repeat (17) run_instr(5'b11000, 0);
    run_instr(5'b11111, 20);

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain act=%0d exp=0", exp_q.size());
    end
    check("halt_final", act, {1'b1, {(OW-1-CNT_W){1'b0}}, CNT_W'(1)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
